strip_sha_trailer: RTL and testbench

- Receive-side counterpart of the transmit signing path.
- Input packets carry a 512-bit signature/digest trailer as their final beat (tlast=1).
- The block splits each packet: payload beats go to a data stream, re-terminated with tlast on the last payload beat. The trailer beat goes to a separate signature stream that feeds the verification pipeline.
- Sits between the network/host input and the sha512/eddsa verify chain plus the payload FIFO; it also keeps packet and error statistics.

---
 rtl/strip_sha_trailer.sv | 134 +++++++++++++
 tb/tb_strip_sha_trailer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strip_sha_trailer.sv
// Splits each packet into payload beats (re-terminated on the last payload beat) and a 512-bit trailer beat.
// Payload beat leaves one cycle after the next beat of its packet is accepted; the input stalls unless both outputs can take a beat.
module strip_sha_trailer #(
   parameter  int DATA_BITS = 512,
   parameter  int ID_BITS   = 6,
   localparam int KEEP_BITS = DATA_BITS / 8
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [DATA_BITS-1:0] s_axis_tdata,
   input  logic [KEEP_BITS-1:0] s_axis_tkeep,
   input  logic [ID_BITS-1:0]   s_axis_tid,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [DATA_BITS-1:0] m_data_tdata,
   output logic [KEEP_BITS-1:0] m_data_tkeep,
   output logic [ID_BITS-1:0]   m_data_tid,
   output logic                 m_data_tlast,
   output logic                 m_data_tvalid,
   input  logic                 m_data_tready,
   output logic [DATA_BITS-1:0] m_sig_tdata,
   output logic [KEEP_BITS-1:0] m_sig_tkeep,
   output logic [ID_BITS-1:0]   m_sig_tid,
   output logic                 m_sig_tlast,
   output logic                 m_sig_tvalid,
   input  logic                 m_sig_tready,
   output logic [31:0]          pkt_count,
   output logic [15:0]          runt_count,
   output logic [15:0]          tid_err_count
);

   logic                 r_h_v;
   logic [DATA_BITS-1:0] r_h_data;
   logic [KEEP_BITS-1:0] r_h_keep;
   logic [ID_BITS-1:0]   r_h_tid;

   logic                 r_d_v;
   logic [DATA_BITS-1:0] r_d_data;
   logic [KEEP_BITS-1:0] r_d_keep;
   logic [ID_BITS-1:0]   r_d_tid;
   logic                 r_d_last;

   logic                 r_s_v;
   logic [DATA_BITS-1:0] r_s_data;
   logic [KEEP_BITS-1:0] r_s_keep;
   logic [ID_BITS-1:0]   r_s_tid;

   logic [31:0]          r_pkt_count;
   logic [15:0]          r_runt_count;
   logic [15:0]          r_tid_err_count;

   logic                 w_d_free;
   logic                 w_s_free;
   logic                 w_acc;
   logic                 w_d_load;
   logic                 w_s_load;

   // Ready is deliberately combinational from both downstream readies.
   assign w_d_free      = !r_d_v | m_data_tready;
   assign w_s_free      = !r_s_v | m_sig_tready;
   assign s_axis_tready = w_d_free & w_s_free & !areset;
   assign w_acc         = s_axis_tvalid & s_axis_tready;
   assign w_d_load      = w_acc & r_h_v;
   assign w_s_load      = w_acc & s_axis_tlast;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_h_v           <= 1'b0;
         r_d_v           <= 1'b0;
         r_s_v           <= 1'b0;
         r_pkt_count     <= 32'd0;
         r_runt_count    <= 16'd0;
         r_tid_err_count <= 16'd0;
      end else begin
         if (w_acc)
            r_h_v <= !s_axis_tlast;

         if (w_d_load)
            r_d_v <= 1'b1;
         else if (m_data_tready)
            r_d_v <= 1'b0;

         if (w_s_load)
            r_s_v <= 1'b1;
         else if (m_sig_tready)
            r_s_v <= 1'b0;

         if (w_s_load)
            r_pkt_count <= r_pkt_count + 32'd1;
         if (w_s_load && !r_h_v && (r_runt_count != 16'hFFFF))
            r_runt_count <= r_runt_count + 16'd1;
         if (w_d_load && (s_axis_tid != r_h_tid) && (r_tid_err_count != 16'hFFFF))
            r_tid_err_count <= r_tid_err_count + 16'd1;
      end
   end

   // Datapath registers carry no reset; their contents are ignored while the matching valid is low.
   always_ff @(posedge aclk) begin
      if (w_acc && !s_axis_tlast) begin
         r_h_data <= s_axis_tdata;
         r_h_keep <= s_axis_tkeep;
         r_h_tid  <= s_axis_tid;
      end
      if (w_d_load) begin
         r_d_data <= r_h_data;
         r_d_keep <= r_h_keep;
         r_d_tid  <= r_h_tid;
         r_d_last <= s_axis_tlast;
      end
      if (w_s_load) begin
         r_s_data <= s_axis_tdata;
         r_s_keep <= s_axis_tkeep;
         r_s_tid  <= s_axis_tid;
      end
   end

   assign m_data_tdata  = r_d_data;
   assign m_data_tkeep  = r_d_keep;
   assign m_data_tid    = r_d_tid;
   assign m_data_tlast  = r_d_last;
   assign m_data_tvalid = r_d_v;

   assign m_sig_tdata   = r_s_data;
   assign m_sig_tkeep   = r_s_keep;
   assign m_sig_tid     = r_s_tid;
   assign m_sig_tlast   = 1'b1;
   assign m_sig_tvalid  = r_s_v;

   assign pkt_count     = r_pkt_count;
   assign runt_count    = r_runt_count;
   assign tid_err_count = r_tid_err_count;

endmodule

// File: tb/tb_strip_sha_trailer.sv
// Randomized scoreboard bench for strip_sha_trailer: packets are modelled as whole beat lists and
// split into expected payload/trailer queues that a negedge monitor checks against the DUT outputs.
module tb_strip_sha_trailer;
   localparam int DB = 512;
   localparam int IB = 6;
   localparam int KB = DB / 8;

   logic          aclk = 1'b0;
   logic          areset;
   logic [DB-1:0] s_axis_tdata;
   logic [KB-1:0] s_axis_tkeep;
   logic [IB-1:0] s_axis_tid;
   logic          s_axis_tlast;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DB-1:0] m_data_tdata;
   logic [KB-1:0] m_data_tkeep;
   logic [IB-1:0] m_data_tid;
   logic          m_data_tlast;
   logic          m_data_tvalid;
   logic          m_data_tready;
   logic [DB-1:0] m_sig_tdata;
   logic [KB-1:0] m_sig_tkeep;
   logic [IB-1:0] m_sig_tid;
   logic          m_sig_tlast;
   logic          m_sig_tvalid;
   logic          m_sig_tready;
   logic [31:0]   pkt_count;
   logic [15:0]   runt_count;
   logic [15:0]   tid_err_count;

   strip_sha_trailer #(.DATA_BITS(DB), .ID_BITS(IB)) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tid(s_axis_tid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_data_tdata(m_data_tdata), .m_data_tkeep(m_data_tkeep), .m_data_tid(m_data_tid),
      .m_data_tlast(m_data_tlast), .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
      .m_sig_tdata(m_sig_tdata), .m_sig_tkeep(m_sig_tkeep), .m_sig_tid(m_sig_tid),
      .m_sig_tlast(m_sig_tlast), .m_sig_tvalid(m_sig_tvalid), .m_sig_tready(m_sig_tready),
      .pkt_count(pkt_count), .runt_count(runt_count), .tid_err_count(tid_err_count)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [DB-1:0] dat;
      logic [KB-1:0] keep;
      logic [IB-1:0] id;
      logic          last;
   } beat_t;

   beat_t exp_d[$];
   beat_t exp_s[$];
   int    checks = 0;
   int    errors = 0;
   int    m_pkt = 0;
   int    m_runt = 0;
   int    m_tiderr = 0;
   bit    rnd_rdy = 1'b0;
   bit    chk_cosync = 1'b0;
   bit    busy = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", nm, got, req);
      end
   endtask

   function automatic logic [DB-1:0] r512();
      logic [DB-1:0] r;
      for (int i = 0; i < DB / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Scoreboard monitor: a transfer is committed at the next posedge when valid&ready at negedge.
   always @(negedge aclk) begin
      beat_t got;
      beat_t e;
      if (!areset) begin
         if (m_data_tvalid && m_data_tready) begin
            got = {m_data_tdata, m_data_tkeep, m_data_tid, m_data_tlast};
            checks++;
            if (exp_d.size() == 0) begin
               errors++;
               $display("FAIL data_unexpected got id=%0d last=%0b required none", m_data_tid, m_data_tlast);
            end else begin
               e = exp_d.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL data_beat got id=%0d last=%0b keep=%h dat=%h required id=%0d last=%0b keep=%h dat=%h",
                           got.id, got.last, got.keep, got.dat, e.id, e.last, e.keep, e.dat);
               end
            end
         end
         if (m_sig_tvalid && m_sig_tready) begin
            got = {m_sig_tdata, m_sig_tkeep, m_sig_tid, m_sig_tlast};
            checks++;
            if (exp_s.size() == 0) begin
               errors++;
               $display("FAIL sig_unexpected got id=%0d required none", m_sig_tid);
            end else begin
               e = exp_s.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL sig_beat got id=%0d last=%0b keep=%h dat=%h required id=%0d last=%0b keep=%h dat=%h",
                           got.id, got.last, got.keep, got.dat, e.id, e.last, e.keep, e.dat);
               end
            end
         end
         if (chk_cosync && m_data_tvalid && m_data_tlast)
            chk("trailer_with_last_payload", m_sig_tvalid, 1);
      end
   end

   initial begin
      forever begin
         @(posedge aclk);
         #1;
         if (rnd_rdy) begin
            m_data_tready = ($urandom_range(0, 3) != 0);
            m_sig_tready  = ($urandom_range(0, 2) != 0);
         end
      end
   end

   task automatic send_beat(input beat_t b, input bit gap);
      int tmo;
      if (gap) begin
         s_axis_tvalid = 1'b0;
         repeat ($urandom_range(1, 2)) begin @(posedge aclk); #1; end
      end
      s_axis_tdata  = b.dat;
      s_axis_tkeep  = b.keep;
      s_axis_tid    = b.id;
      s_axis_tlast  = b.last;
      s_axis_tvalid = 1'b1;
      tmo = 0;
      forever begin
         @(negedge aclk);
         if (s_axis_tready) begin
            @(posedge aclk); #1;
            break;
         end
         @(posedge aclk); #1;
         tmo++;
         if (tmo > 500) begin
            chk("input_accept_timeout", 1, 0);
            break;
         end
      end
      s_axis_tvalid = 1'b0;
   endtask

   // Reference model: a packet of n beats yields n-1 payload beats (last one flagged) and one trailer.
   task automatic send_pkt(input int n, input logic [IB-1:0] tid0, input int chg_at, input bit gaps);
      beat_t b[16];
      beat_t e;
      logic [IB-1:0] tid1;
      tid1 = tid0 + 1'b1;
      for (int i = 0; i < n; i++) begin
         b[i].dat  = r512();
         b[i].keep = {$urandom, $urandom};
         b[i].id   = (chg_at >= 0 && i >= chg_at) ? tid1 : tid0;
         b[i].last = (i == n - 1);
      end
      for (int i = 0; i < n - 1; i++) begin
         e = b[i];
         e.last = (i == n - 2);
         exp_d.push_back(e);
      end
      e = b[n-1];
      e.last = 1'b1;
      exp_s.push_back(e);
      m_pkt++;
      if (n == 1 && m_runt < 65535) m_runt++;
      for (int i = 1; i < n; i++)
         if (b[i].id != b[i-1].id && m_tiderr < 65535) m_tiderr++;
      for (int i = 0; i < n; i++)
         send_beat(b[i], gaps && ($urandom_range(0, 3) == 0));
   endtask

   task automatic drain(input string nm);
      int t;
      t = 0;
      while ((exp_d.size() != 0 || exp_s.size() != 0) && t < 3000) begin
         @(posedge aclk);
         t++;
      end
      repeat (3) @(posedge aclk);
      #1;
      chk({nm, "_drain_timeout"}, (t >= 3000), 0);
      chk({nm, "_data_idle"}, m_data_tvalid, 0);
      chk({nm, "_sig_idle"}, m_sig_tvalid, 0);
      chk({nm, "_pkt_count"}, pkt_count, m_pkt);
      chk({nm, "_runt_count"}, runt_count, m_runt);
      chk({nm, "_tid_err_count"}, tid_err_count, m_tiderr);
   endtask

   task automatic wait_idle_driver();
      int t;
      t = 0;
      while (busy && t < 3000) begin @(posedge aclk); t++; end
      #1;
      chk("driver_timeout", (t >= 3000), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "global timeout");
   end

   initial begin
      beat_t pb;
      areset        = 1'b1;
      m_data_tready = 1'b1;
      m_sig_tready  = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tid    = '0;
      s_axis_tlast  = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("reset_in_ready", s_axis_tready, 0);
      chk("reset_data_valid", m_data_tvalid, 0);
      chk("reset_sig_valid", m_sig_tvalid, 0);
      chk("reset_pkt_count", pkt_count, 0);
      chk("reset_runt_count", runt_count, 0);
      chk("reset_tid_err_count", tid_err_count, 0);
      @(negedge aclk);
      areset = 1'b0;
      @(posedge aclk); #1;

      chk_cosync = 1'b1;
      send_pkt(4, 6'd3, -1, 1'b0);
      drain("basic");
      send_pkt(1, 6'd5, -1, 1'b0);
      drain("runt");
      chk_cosync = 1'b0;

      // Payload backpressure for five cycles during a 6-beat packet.
      fork begin busy = 1'b1; send_pkt(6, 6'd9, -1, 1'b0); busy = 1'b0; end join_none
      @(posedge aclk); @(posedge aclk); #1;
      m_data_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         chk("stall_in_ready", s_axis_tready, 0);
         chk("stall_data_valid", m_data_tvalid, 1);
         @(posedge aclk); #1;
      end
      m_data_tready = 1'b1;
      wait_idle_driver();
      drain("data_stall");

      // Trailer backpressure with a second packet queued behind it.
      m_sig_tready = 1'b0;
      fork begin busy = 1'b1; send_pkt(3, 6'd7, -1, 1'b0); send_pkt(3, 6'd8, -1, 1'b0); busy = 1'b0; end join_none
      repeat (8) @(posedge aclk);
      @(negedge aclk);
      chk("sig_stall_in_ready", s_axis_tready, 0);
      chk("sig_stall_sig_valid", m_sig_tvalid, 1);
      @(posedge aclk); #1;
      m_sig_tready = 1'b1;
      wait_idle_driver();
      drain("sig_stall");

      send_pkt(4, 6'd1, 2, 1'b0);
      drain("tid_change");

      rnd_rdy = 1'b1;
      for (int p = 0; p < 40; p++)
         send_pkt($urandom_range(1, 6), 6'($urandom_range(0, 63)),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : -1, 1'b1);
      rnd_rdy = 1'b0;
      @(posedge aclk); #1;
      m_data_tready = 1'b1;
      m_sig_tready  = 1'b1;
      drain("random");

      // Reset with two payload beats accepted (one in the output register, one held).
      m_data_tready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pb.dat = r512(); pb.keep = '1; pb.id = 6'd4; pb.last = 1'b0;
         send_beat(pb, 1'b0);
      end
      @(posedge aclk);
      #3;
      areset = 1'b1;
      #1;
      m_pkt = 0; m_runt = 0; m_tiderr = 0;
      chk("midreset_data_valid", m_data_tvalid, 0);
      chk("midreset_sig_valid", m_sig_tvalid, 0);
      chk("midreset_in_ready", s_axis_tready, 0);
      chk("midreset_pkt_count", pkt_count, 0);
      chk("midreset_runt_count", runt_count, 0);
      chk("midreset_tid_err_count", tid_err_count, 0);
      @(negedge aclk);
      areset = 1'b0;
      @(posedge aclk); #1;
      m_data_tready = 1'b1;
      send_pkt(3, 6'd2, -1, 1'b0);
      drain("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
